scale_seq: RTL

//   Sequencer that scales a 16-lane FP32 score vector by 1/sqrt(d_k) using ONE shared
//   FP32 divider core instead of one divider per lane. Latches a 512-bit score vector,

---
 rtl/scale_seq.sv | 96 +++++++++
 1 files changed

// File: rtl/scale_seq.sv
// Scales a LANES-wide FP32 score vector by 1/sqrt(d_k) through one shared divider core,
// issuing lanes in order over the divider's stb/ack handshake and collecting the quotients.
module scale_seq #(
    parameter int              LANES   = 16,
    parameter int              DW      = 32,
    parameter logic [DW-1:0]   DIVISOR = 32'h40B504F3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LANES*DW-1:0] score,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LANES*DW-1:0] scaled_score,
    output logic                done,
    output logic                busy,
    output logic [DW-1:0]       div_a,
    output logic [DW-1:0]       div_b,
    output logic                div_a_stb,
    output logic                div_b_stb,
    input  logic                div_a_ack,
    input  logic                div_b_ack,
    input  logic [DW-1:0]       div_z,
    input  logic                div_z_stb,
    output logic                div_z_ack
);
    localparam int              LW   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0]   LAST = LW'(LANES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_Z, DONE} state_t;

    state_t                state, state_nxt;
    logic [LW-1:0]         lane;
    logic [LANES*DW-1:0]   vec;
    logic                  done_q;
    logic                  accept;

    assign accept    = (state == IDLE) && in_valid;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == LOAD) || (state == WAIT_Z);
    assign div_z_ack = (state == WAIT_Z);
    assign done      = done_q;
    assign div_a     = vec[int'(lane)*DW +: DW];
    assign div_b     = DIVISOR;

    always_comb begin
        // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = LOAD;
            // Each operand strobe is either already retired or transferring this cycle.
            LOAD:    if ((!div_a_stb || div_a_ack) && (!div_b_stb || div_b_ack)) state_nxt = WAIT_Z;
            WAIT_Z:  if (div_z_stb) state_nxt = (lane == LAST) ? DONE : LOAD;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: the latched vector is pure data written only on accept, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) vec <= score;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane         <= '0;
            div_a_stb    <= 1'b0;
            div_b_stb    <= 1'b0;
            done_q       <= 1'b0;
            scaled_score <= '0;
        end else begin
            done_q <= (state == WAIT_Z) && (state_nxt == DONE);
            if (accept) lane <= '0;

            if (state != LOAD && state_nxt == LOAD) begin
                div_a_stb <= 1'b1;
                div_b_stb <= 1'b1;
            end else begin
                if (div_a_ack) div_a_stb <= 1'b0;
                if (div_b_ack) div_b_stb <= 1'b0;
            end

            if (state == WAIT_Z && div_z_stb) begin
                scaled_score[int'(lane)*DW +: DW] <= div_z;
                if (lane != LAST) lane <= lane + LW'(1);
            end
        end
    end
endmodule
